// File: rtl/muldiv_if.sv
// Handshake and result bundle between the execute stage and the iterative
// multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             dbz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, dbz, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, dbz, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit that owns HI/LO; one bit per cycle,
// sign handling by magnitude at capture and correction in the final cycle.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO written here directly
// RUN   | one shift-add / shift-subtract step per cycle
// FIN   | sign correction, HI/LO write, done pulse
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state;
    logic [2:0]         op_r;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg_q;
    logic               neg_r;
    logic               zero_div;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;
    logic               dbz_r;

    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.dbz  = dbz_r;

    logic               in_signed;
    logic               a_neg;
    logic               b_neg;
    logic               in_div;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               is_div;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [2*WIDTH-1:0] hilo;

    always_comb begin
        in_signed = ~bus.op[0];
        in_div    = (bus.op[2:1] == 2'b01);
        a_neg     = in_signed & bus.a[WIDTH-1];
        b_neg     = in_signed & bus.b[WIDTH-1];
        a_mag     = a_neg ? -bus.a : bus.a;
        b_mag     = b_neg ? -bus.b : bus.b;
    end

    // acc holds {partial product, multiplier} for multiply and
    // {partial remainder, dividend/quotient} for divide.
    always_comb begin
        is_div    = (op_r[2:1] == 2'b01);
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
        div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod_s    = neg_q ? -acc : acc;
        quo_s     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_s     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        hilo      = {hi_r, lo_r};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_r     <= '0;
            opnd     <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            zero_div <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (!bus.op[3]) begin
                            op_r     <= bus.op[2:0];
                            neg_q    <= a_neg ^ b_neg;
                            neg_r    <= a_neg;
                            zero_div <= in_div & (bus.b == '0);
                            cnt      <= CW'(WIDTH-1);
                            busy_r   <= 1'b1;
                            state    <= RUN;
                            if (in_div) begin
                                acc  <= {{WIDTH{1'b0}}, a_mag};
                                opnd <= b_mag;
                            end else begin
                                acc  <= {{WIDTH{1'b0}}, b_mag};
                                opnd <= a_mag;
                            end
                        end else if (bus.op == 4'b1000) begin
                            hi_r <= bus.a;
                        end else if (bus.op == 4'b1001) begin
                            lo_r <= bus.a;
                        end
                    end
                end
                RUN: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) state <= FIN;
                end
                FIN: begin
                    case (op_r[2:1])
                        2'b00: {hi_r, lo_r} <= prod_s;
                        2'b01: begin
                            // With a zero divisor the remainder path already
                            // reconstructs the dividend, so only LO is forced.
                            hi_r <= rem_s;
                            lo_r <= zero_div ? {WIDTH{1'b1}} : quo_s;
                        end
                        2'b10:   {hi_r, lo_r} <= hilo + prod_s;
                        default: {hi_r, lo_r} <= hilo - prod_s;
                    endcase
                    done_r <= 1'b1;
                    dbz_r  <= zero_div;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic model
// of HI/LO; a second 8-bit instance covers the width-dependent latency.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) m ();
    muldiv_if #(.WIDTH(8))  m8 ();

    muldiv_unit #(.WIDTH(32)) dut   (.clk(clk), .reset(reset), .bus(m));
    muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(m8));

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;
    logic        mdbz = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural HI/LO pair.
    function automatic void model_apply(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        logic [63:0] p, hl;
        sx = $signed(x);
        sy = $signed(y);
        hl = {mhi, mlo};
        mdbz = 1'b0;
        case (o)
            4'd0, 4'd4, 4'd6: p = sx * sy;
            default:          p = {32'h0, x} * {32'h0, y};
        endcase
        case (o)
            4'd0, 4'd1: hl = p;
            4'd4, 4'd5: hl = hl + p;
            4'd6, 4'd7: hl = hl - p;
            4'd2, 4'd3: begin
                if (y == 32'h0) begin
                    hl = {x, 32'hFFFF_FFFF};
                    mdbz = 1'b1;
                end else if (o == 4'd2) begin
                    hl = {32'(sx % sy), 32'(sx / sy)};
                end else begin
                    hl = {x % y, x / y};
                end
            end
            4'd8: hl[63:32] = x;
            4'd9: hl[31:0] = x;
            default: ;
        endcase
        {mhi, mlo} = hl;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        m.start = 1'b1;
        m.op = o;
        m.a = x;
        m.b = y;
        cyc();
        m.start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat = 0;
        bcnt = 0;
        while (m.done !== 1'b1 && lat < 200) begin
            if (m.busy === 1'b1) bcnt++;
            cyc();
            lat++;
        end
    endtask

    task automatic do_check(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int lat, bcnt;
        model_apply(o, x, y);
        issue(o, x, y);
        if (o < 4'd8) begin
            wait_done(lat, bcnt);
            chk({tag, "_lat"}, lat, 33);
            chk({tag, "_busy"}, bcnt, 33);
            chk({tag, "_hi"}, m.hi, mhi);
            chk({tag, "_lo"}, m.lo, mlo);
            chk({tag, "_dbz"}, m.dbz, mdbz);
        end else begin
            chk({tag, "_nobusy"}, {m.busy, m.done}, 2'b00);
            chk({tag, "_hi"}, m.hi, mhi);
            chk({tag, "_lo"}, m.lo, mlo);
        end
    endtask

    initial begin
        int lat, bcnt, dcnt;
        logic [3:0] o;
        logic [31:0] x, y;

        m.start = 1'b0; m.op = '0; m.a = '0; m.b = '0;
        m8.start = 1'b0; m8.op = '0; m8.a = '0; m8.b = '0;
        repeat (3) cyc();
        chk("reset_hi", m.hi, 0);
        chk("reset_lo", m.lo, 0);
        chk("reset_flags", {m.busy, m.done, m.dbz}, 3'b000);
        reset = 1'b0;
        cyc();

        do_check("mult_neg", 4'd0, 32'hFFFF_FFFE, 32'd3);
        chk("mult_neg_const", {m.hi, m.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        cyc();
        chk("done_pulse", m.done, 1'b0);
        do_check("div_neg", 4'd2, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg_const", {m.hi, m.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_check("divu", 4'd3, 32'hFFFF_FFF9, 32'd2);
        do_check("divu_zero", 4'd3, 32'd7, 32'd0);
        chk("divu_zero_const", {m.dbz, m.hi, m.lo}, {1'b1, 64'h0000_0007_FFFF_FFFF});
        cyc();
        chk("dbz_pulse", {m.dbz, m.done}, 2'b00);
        do_check("div_ovf", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_const", {m.dbz, m.hi, m.lo}, {1'b0, 64'h0000_0000_8000_0000});
        do_check("mthi", 4'd8, 32'd0, 32'd0);
        do_check("mtlo", 4'd9, 32'hFFFF_FFFF, 32'd0);
        do_check("maddu", 4'd5, 32'd1, 32'd1);
        chk("maddu_const", {m.hi, m.lo}, 64'h0000_0001_0000_0000);
        do_check("msub", 4'd6, 32'd1, 32'd2);
        chk("msub_const", {m.hi, m.lo}, 64'h0000_0000_FFFF_FFFE);

        // Starts while busy are dropped, including an MTHI.
        model_apply(4'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        issue(4'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (3) cyc();
        m.start = 1'b1; m.op = 4'd3; m.a = 32'd100; m.b = 32'd7;
        cyc();
        m.op = 4'd8; m.a = 32'hDEAD_BEEF;
        cyc();
        m.start = 1'b0;
        wait_done(lat, bcnt);
        chk("stall_lat", lat, 28);
        chk("stall_hi", m.hi, mhi);
        chk("stall_lo", m.lo, mlo);
        do_check("b2b", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Reset in the middle of a multiply.
        issue(4'd0, 32'd12345, 32'd678);
        repeat (9) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        mhi = '0; mlo = '0;
        chk("midrst_hilo", {m.hi, m.lo}, 64'h0);
        chk("midrst_busy", m.busy, 1'b0);
        dcnt = 0;
        repeat (40) begin
            if (m.done === 1'b1) dcnt++;
            cyc();
        end
        chk("midrst_nodone", dcnt, 0);
        do_check("multu_small", 4'd1, 32'd5, 32'd6);
        chk("multu_small_const", {m.hi, m.lo}, 64'd30);

        // 8-bit instance: latency tracks WIDTH.
        m8.start = 1'b1; m8.op = 4'd0; m8.a = 8'hFE; m8.b = 8'd3;
        cyc();
        m8.start = 1'b0;
        lat = 0;
        while (m8.done !== 1'b1 && lat < 100) begin
            cyc();
            lat++;
        end
        chk("w8_lat", lat, 9);
        chk("w8_hilo", {m8.hi, m8.lo}, 16'hFFFA);

        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 15));
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) x = 32'h8000_0000;
            if ($urandom_range(0, 5) == 0) y = 32'hFFFF_FFFF;
            do_check($sformatf("rnd%0d_op%0d", i, o), o, x, y);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair, with a start/busy/done handshake. It sits beside the single-cycle ALU in the execute stage and is generalised in operand width. It replaces the combinational multiplier and divider with an iterative radix-2 datapath. It adds the behaviour the ALU lacks: a defined handshake, divide-by-zero reporting, and accumulate operations that are atomic against HI/LO.

## Interface
- WIDTH, 32, operand and HI/LO width; any value 4..64
- clk  input  1  rising-edge clock; one clock domain
- reset  input  1  synchronous, active-high; sampled on rising clk
- start  input  1  request; accepted only when busy=0
- op  input  4  operation code, sampled with start:
  - 0000 MULT
  - 0001 MULTU
  - 0010 DIV
  - 0011 DIVU
  - 0100 MADD
  - 0101 MADDU
  - 0110 MSUB
  - 0111 MSUBU
  - 1000 MTHI
  - 1001 MTLO
  - any other code: no-op
- a  input  WIDTH  operand 1 (multiplicand / dividend / MTHI-MTLO source)
- b  input  WIDTH  operand 2 (multiplier / divisor)
- busy  output  1  iterative operation in progress
- done  output  1  one-cycle pulse; HI/LO updated on the same edge
- dbz  output  1  divide by zero; valid while done=1, 0 otherwise
- hi  output  WIDTH  HI register (read directly for mfhi)
- lo  output  WIDTH  LO register (read directly for mflo)

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE, start=1, op in 0000..0111:
  - capture a, b and op into internal registers
  - iteration counter ← WIDTH-1
  - go to RUN; busy=1 from the next cycle
- Signed ops (MULT, DIV, MADD, MSUB):
  - operands are converted to magnitudes at capture
  - result signs are recorded at capture
- IDLE, start=1, op=MTHI/MTLO:
  - hi (or lo) ← a on the same edge
  - no busy, no done, state stays IDLE
- IDLE, start=1, other op: ignored.
- RUN, one radix-2 step per cycle:
  - multiply: shift-add into a 2·WIDTH product register
  - divide: restoring shift-subtract, producing quotient and remainder
  - leave RUN after the step with counter=0; go to FIN
- FIN, one cycle, then IDLE:
  - apply sign correction
  - MULT/MULTU: {hi,lo} ← product
  - MADD/MADDU: {hi,lo} ← {hi,lo} + product
  - MSUB/MSUBU: {hi,lo} ← {hi,lo} − product
  - accumulate arithmetic is modulo 2^(2·WIDTH)
  - accumulate ops treat {hi,lo} as signed for signed ops, unsigned for u-ops; the bit result is identical either way
  - DIV/DIVU: lo ← quotient, hi ← remainder
  - DIV truncates toward zero; remainder takes the sign of the dividend
  - done=1 during FIN's edge output cycle
- Divide by zero (b=0 at capture):
  - lo ← all ones, hi ← a
  - dbz=1 with done
  - the operation still takes the full latency
- Signed overflow (DIV of MIN by −1): lo ← MIN, hi ← 0, dbz=0.
- start while busy=1: ignored; no queuing.
- hi/lo are written only in FIN, or on MTHI/MTLO acceptance.
  - Since start is ignored while busy, accumulate reads HI/LO exactly as they were at accept.
- Reset:
  - hi, lo, busy, done, dbz ← 0
  - state ← IDLE
  - a reset mid-operation discards the operation; no HI/LO write occurs.

## Timing
- Accept edge k:
  - busy=1 during cycles k+1 .. k+WIDTH+1
  - hi/lo updated and done=1 after edge k+WIDTH+1
  - busy=0 from that same cycle
  - total latency WIDTH+1 cycles
- A new start is accepted on the edge immediately after done (back-to-back throughput WIDTH+2 cycles).
- MTHI/MTLO: zero latency; the value is visible the cycle after the accept edge.
- hi/lo are register outputs with no combinational path from inputs.
- done and dbz are registered single-cycle pulses.

## Test plan
- WIDTH=32, MULT a=0xFFFFFFFE, b=3 → done exactly 33 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high 33 cycles.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU same operands → lo=0x7FFFFFFC, hi=1.
- DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=7, dbz=1 for one cycle. Then DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, dbz=0.
- MTHI a=0, MTLO a=0xFFFFFFFF, then MADDU a=1, b=1 → hi=1, lo=0. Then MSUB a=1, b=2 → hi=0, lo=0xFFFFFFFE.
- Back-to-back and stall:
  - second start while busy → ignored; hi/lo reflect only the first op
  - start on the cycle after done → accepted
  - MTHI pulsed while busy → hi unchanged
- Reset asserted 10 cycles into a MULT → hi=lo=0, busy=0, done never pulses. A following MULTU 5×6 → lo=30, hi=0. Repeat scenario 1 with WIDTH=8: latency 9 cycles.
